// File: rtl/membridge_pkg.sv
// membridge_pkg: definitions shared by the DDR4 bank scheduler and the
// address mapper.
//   - address field widths (ROW_W, COL_W, BG_W, BA_W) and NUM_BANKS
//   - PHY command opcodes (cmd_op_e)
//   - scheduler FSM states (sched_state_e)
//   - the latched request record (sched_req_t)
package membridge_pkg;

  localparam int NUM_BANKS = 16;
  localparam int ROW_W     = 16;
  localparam int COL_W     = 10;
  localparam int BG_W      = 2;
  localparam int BA_W      = 2;
  localparam int BANK_W    = BG_W + BA_W;
  // Wide enough for the largest tRP/tRCD (63 cycles)
  localparam int TIMER_W   = 6;

  typedef enum logic [2:0] {
    CMD_NOP  = 3'd0,
    CMD_ACT  = 3'd1,
    CMD_PRE  = 3'd2,
    CMD_RD   = 3'd3,
    CMD_WR   = 3'd4,
    CMD_PREA = 3'd5
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_WAIT_RP,
    ST_ACT,
    ST_WAIT_RCD,
    ST_RW,
    ST_PREA,
    ST_WAIT_RPA
  } sched_state_e;

  typedef struct packed {
    logic             we;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [BG_W-1:0]  bg;
    logic [BA_W-1:0]  ba;
  } sched_req_t;

  // Flat bank number used to index the open-row table
  function automatic logic [BANK_W-1:0] bank_index(input logic [BG_W-1:0] bg,
                                                   input logic [BA_W-1:0] ba);
    return {bg, ba};
  endfunction

endpackage

// File: rtl/ddr4_bank_scheduler_if.sv
// ddr4_bank_scheduler_if: request, PHY command and flush signals of the
// bank scheduler.
//   master : the environment (address mapper side + PHY side)
//   slave  : the scheduler itself
//   req_*  : decoded request with valid/ready handshake
//   cmd_*  : PHY command with valid/ready handshake
//   flush / flush_done / busy : precharge-all control and status
interface ddr4_bank_scheduler_if;
  import membridge_pkg::*;

  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [ROW_W-1:0] req_row;
  logic [COL_W-1:0] req_col;
  logic [BG_W-1:0]  req_bg;
  logic [BA_W-1:0]  req_ba;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [BG_W-1:0]  cmd_bg;
  logic [BA_W-1:0]  cmd_ba;
  logic [ROW_W-1:0] cmd_row;
  logic [COL_W-1:0] cmd_col;
  logic             cmd_ap;

  logic             flush;
  logic             flush_done;
  logic             busy;

  modport master (
    output req_valid, req_we, req_row, req_col, req_bg, req_ba,
    output cmd_ready, flush,
    input  req_ready, cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_row, cmd_col,
    input  cmd_ap, flush_done, busy
  );

  modport slave (
    input  req_valid, req_we, req_row, req_col, req_bg, req_ba,
    input  cmd_ready, flush,
    output req_ready, cmd_valid, cmd_op, cmd_bg, cmd_ba, cmd_row, cmd_col,
    output cmd_ap, flush_done, busy
  );

endinterface

// File: rtl/ddr4_open_row_table.sv
// ddr4_open_row_table: per-bank open flag and open row for all 16 banks.
//   sys_clk, sys_rst_n  : clock, asynchronous active-low reset (all closed)
//   lk_idx, lk_row      : combinational lookup -> lk_open, lk_hit
//   any_open            : at least one bank has an open row
//   set_en/idx/row      : mark a bank open on a row (ACT)
//   clr_en/idx          : mark one bank closed (PRE or auto-precharge)
//   clr_all             : mark every bank closed (PREA); wins over set/clr
module ddr4_open_row_table
  import membridge_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [BANK_W-1:0] lk_idx,
  input  logic [ROW_W-1:0]  lk_row,
  output logic              lk_open,
  output logic              lk_hit,
  output logic              any_open,
  input  logic              set_en,
  input  logic [BANK_W-1:0] set_idx,
  input  logic [ROW_W-1:0]  set_row,
  input  logic              clr_en,
  input  logic [BANK_W-1:0] clr_idx,
  input  logic              clr_all
);

  logic [NUM_BANKS-1:0] open_vec;
  logic [ROW_W-1:0]     row_vec [NUM_BANKS];

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic             open_q, open_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
      open_d = open_q;
      row_d  = row_q;
      if (clr_all) begin
        open_d = 1'b0;
      end else if (set_en && set_idx == BANK_W'(gi)) begin
        open_d = 1'b1;
        row_d  = set_row;
      end else if (clr_en && clr_idx == BANK_W'(gi)) begin
        open_d = 1'b0;
      end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        open_q <= 1'b0;
        row_q  <= '0;
      end else begin
        open_q <= open_d;
        row_q  <= row_d;
      end
    end

    assign open_vec[gi] = open_q;
    assign row_vec[gi]  = row_q;
  end

  assign lk_open  = open_vec[lk_idx];
  assign lk_hit   = lk_open && (row_vec[lk_idx] == lk_row);
  assign any_open = |open_vec;

endmodule

// File: rtl/ddr4_bank_scheduler.sv
// ddr4_bank_scheduler: single-request, in-order DDR4 command sequencer.
// Classifies each accepted request against the open-row table and issues
// PRE/ACT/RD/WR with tRP/tRCD spacing from a single down-counter; also runs
// a precharge-all (PREA) flush on request.
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   bus (slave)        : req_* in, cmd_* out, flush in, flush_done/busy out
// Parameters: T_RP, T_RCD (1..63 cycles).
// Build option: MEMBRIDGE_AUTO_PRECHARGE_EN selects closed-page policy
// (RD/WR with auto-precharge, bank closed and tRP waited after every access).
module ddr4_bank_scheduler
  import membridge_pkg::*;
#(
  parameter int unsigned T_RP  = 4,
  parameter int unsigned T_RCD = 4
) (
  input logic                  sys_clk,
  input logic                  sys_rst_n,
  ddr4_bank_scheduler_if.slave bus
);

  localparam logic [TIMER_W-1:0] RP_LOAD  = TIMER_W'(T_RP - 1);
  localparam logic [TIMER_W-1:0] RCD_LOAD = TIMER_W'(T_RCD - 1);

  sched_state_e       state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  sched_req_t         req_q, req_d;
  logic               pending_q, pending_d;
  logic               cmd_valid_q, cmd_valid_d;
  cmd_op_e            cmd_op_q, cmd_op_d;
  logic [BG_W-1:0]    cmd_bg_q, cmd_bg_d;
  logic [BA_W-1:0]    cmd_ba_q, cmd_ba_d;
  logic [ROW_W-1:0]   cmd_row_q, cmd_row_d;
  logic [COL_W-1:0]   cmd_col_q, cmd_col_d;
  logic               cmd_ap_q, cmd_ap_d;
  logic               flush_done_q, flush_done_d;
  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;

  sched_req_t req_in;
  logic       lk_open, lk_hit, any_open;
  logic       tbl_set, tbl_clr, tbl_clr_all;

  assign req_in = {bus.req_we, bus.req_row, bus.req_col, bus.req_bg, bus.req_ba};

  ddr4_open_row_table u_table (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .lk_idx   (bank_index(bus.req_bg, bus.req_ba)),
    .lk_row   (bus.req_row),
    .lk_open  (lk_open),
    .lk_hit   (lk_hit),
    .any_open (any_open),
    .set_en   (tbl_set),
    .set_idx  (bank_index(req_q.bg, req_q.ba)),
    .set_row  (req_q.row),
    .clr_en   (tbl_clr),
    .clr_idx  (bank_index(req_q.bg, req_q.ba)),
    .clr_all  (tbl_clr_all)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    req_d        = req_q;
    // A flush pulse is remembered in any state; repeats simply merge
    pending_d    = pending_q | bus.flush;
    flush_done_d = 1'b0;
    tbl_set      = 1'b0;
    tbl_clr      = 1'b0;
    tbl_clr_all  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          if (any_open) begin
            state_d = ST_PREA;
          end else begin
            flush_done_d = 1'b1;
            pending_d    = 1'b0;
          end
        end else if (bus.req_valid && req_ready_q) begin
          req_d = req_in;
          if (lk_hit)       state_d = ST_RW;
          else if (lk_open) state_d = ST_PRE;
          else              state_d = ST_ACT;
        end
      end

      ST_PRE: begin
        if (bus.cmd_ready) begin
          tbl_clr = 1'b1;
          if (T_RP == 1) begin
            state_d = ST_ACT;
          end else begin
            state_d = ST_WAIT_RP;
            timer_d = RP_LOAD;
          end
        end
      end

      ST_WAIT_RP: begin
        timer_d = timer_q - 1'b1;
        if (timer_q <= TIMER_W'(1)) begin
          timer_d = '0;
`ifdef MEMBRIDGE_AUTO_PRECHARGE_EN
          // Pages never stay open, so tRP here always follows an
          // auto-precharging RD/WR and the request is finished.
          state_d = ST_IDLE;
`else
          state_d = ST_ACT;
`endif
        end
      end

      ST_ACT: begin
        if (bus.cmd_ready) begin
          tbl_set = 1'b1;
          if (T_RCD == 1) begin
            state_d = ST_RW;
          end else begin
            state_d = ST_WAIT_RCD;
            timer_d = RCD_LOAD;
          end
        end
      end

      ST_WAIT_RCD: begin
        timer_d = timer_q - 1'b1;
        if (timer_q <= TIMER_W'(1)) begin
          timer_d = '0;
          state_d = ST_RW;
        end
      end

      ST_RW: begin
        if (bus.cmd_ready) begin
`ifdef MEMBRIDGE_AUTO_PRECHARGE_EN
          tbl_clr = 1'b1;
          if (T_RP == 1) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_RP;
            timer_d = RP_LOAD;
          end
`else
          state_d = ST_IDLE;
`endif
        end
      end

      ST_PREA: begin
        if (bus.cmd_ready) begin
          tbl_clr_all = 1'b1;
          if (T_RP == 1) begin
            state_d      = ST_IDLE;
            flush_done_d = 1'b1;
            pending_d    = 1'b0;
          end else begin
            state_d = ST_WAIT_RPA;
            timer_d = RP_LOAD;
          end
        end
      end

      ST_WAIT_RPA: begin
        timer_d = timer_q - 1'b1;
        if (timer_q <= TIMER_W'(1)) begin
          timer_d      = '0;
          state_d      = ST_IDLE;
          flush_done_d = 1'b1;
          pending_d    = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered,
    // aligned with the state they belong to, and stay frozen while stalled.
    cmd_valid_d = 1'b0;
    cmd_op_d    = CMD_NOP;
    cmd_bg_d    = '0;
    cmd_ba_d    = '0;
    cmd_row_d   = '0;
    cmd_col_d   = '0;
    cmd_ap_d    = 1'b0;
    case (state_d)
      ST_PRE: begin
        cmd_valid_d = 1'b1;
        cmd_op_d    = CMD_PRE;
        cmd_bg_d    = req_d.bg;
        cmd_ba_d    = req_d.ba;
      end
      ST_ACT: begin
        cmd_valid_d = 1'b1;
        cmd_op_d    = CMD_ACT;
        cmd_bg_d    = req_d.bg;
        cmd_ba_d    = req_d.ba;
        cmd_row_d   = req_d.row;
      end
      ST_RW: begin
        cmd_valid_d = 1'b1;
        cmd_op_d    = req_d.we ? CMD_WR : CMD_RD;
        cmd_bg_d    = req_d.bg;
        cmd_ba_d    = req_d.ba;
        cmd_col_d   = req_d.col;
`ifdef MEMBRIDGE_AUTO_PRECHARGE_EN
        cmd_ap_d    = 1'b1;
`endif
      end
      ST_PREA: begin
        cmd_valid_d = 1'b1;
        cmd_op_d    = CMD_PREA;
      end
      default: ;
    endcase

    req_ready_d = (state_d == ST_IDLE) && !pending_d;
    busy_d      = (state_d != ST_IDLE) || pending_d;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      req_q        <= '0;
      pending_q    <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_op_q     <= CMD_NOP;
      cmd_bg_q     <= '0;
      cmd_ba_q     <= '0;
      cmd_row_q    <= '0;
      cmd_col_q    <= '0;
      cmd_ap_q     <= 1'b0;
      flush_done_q <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      req_q        <= req_d;
      pending_q    <= pending_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_op_q     <= cmd_op_d;
      cmd_bg_q     <= cmd_bg_d;
      cmd_ba_q     <= cmd_ba_d;
      cmd_row_q    <= cmd_row_d;
      cmd_col_q    <= cmd_col_d;
      cmd_ap_q     <= cmd_ap_d;
      flush_done_q <= flush_done_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.cmd_valid  = cmd_valid_q;
  assign bus.cmd_op     = cmd_op_q;
  assign bus.cmd_bg     = cmd_bg_q;
  assign bus.cmd_ba     = cmd_ba_q;
  assign bus.cmd_row    = cmd_row_q;
  assign bus.cmd_col    = cmd_col_q;
  assign bus.cmd_ap     = cmd_ap_q;
  assign bus.flush_done = flush_done_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ddr4_bank_scheduler.sv
// tb_ddr4_bank_scheduler: self-checking bench for ddr4_bank_scheduler.
// A bank model (open flag + row per bank) decides what each request needs;
// expected commands are checked cycle-exactly against tRP/tRCD spacing
// measured from the actual accept cycle. Honours MEMBRIDGE_AUTO_PRECHARGE_EN.
`timescale 1ns/1ps
module tb_ddr4_bank_scheduler;

  localparam int unsigned T_RP  = 3;
  localparam int unsigned T_RCD = 4;
`ifdef MEMBRIDGE_AUTO_PRECHARGE_EN
  localparam bit AP = 1'b1;
`else
  localparam bit AP = 1'b0;
`endif
  localparam int OP_NOP = 0, OP_ACT = 1, OP_PRE = 2, OP_RD = 3, OP_WR = 4, OP_PREA = 5;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;

  ddr4_bank_scheduler_if bus ();

  ddr4_bank_scheduler #(.T_RP(T_RP), .T_RCD(T_RCD)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Behavioural bank state
  bit          m_open [16];
  logic [15:0] m_row  [16];

  task automatic model_clear();
    for (int b = 0; b < 16; b++) m_open[b] = 1'b0;
  endtask

  // Advance one clock; single-cycle inputs drop back to 0
  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.cmd_ready = 1'b0;
  endtask

  // Current cycle is the one in which the previous accept (request or
  // command) is taking place. The expected command must appear exactly gap
  // cycles later, then be held for stall cycles before cmd_ready is given.
  task automatic expect_cmd(input int op, input int bg, input int ba, input int row,
                            input int col, input bit ap, input int gap, input int stall,
                            input int flush_at, input string tag);
    for (int i = 0; i < gap; i++) begin
      step();
      if (i < gap - 1) begin
        checks++;
        if (bus.cmd_valid !== 1'b0) begin
          failures++;
          $display("FAIL %s_early: cycle=%0d cmd_valid=%0b op=%0d required cmd_valid=0",
                   tag, cyc, bus.cmd_valid, bus.cmd_op);
        end
        if (i == flush_at) bus.flush = 1'b1;
      end
    end
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) step();
      checks++;
      if (bus.cmd_valid !== 1'b1 || bus.cmd_op !== 3'(op) || bus.cmd_bg !== 2'(bg) ||
          bus.cmd_ba !== 2'(ba) || bus.cmd_row !== 16'(row) || bus.cmd_col !== 10'(col) ||
          bus.cmd_ap !== ap) begin
        failures++;
        $display("FAIL %s_cmd: cycle=%0d got v=%0b op=%0d bg=%0d ba=%0d row=%h col=%h ap=%0b required v=1 op=%0d bg=%0d ba=%0d row=%h col=%h ap=%0b",
                 tag, cyc, bus.cmd_valid, bus.cmd_op, bus.cmd_bg, bus.cmd_ba, bus.cmd_row,
                 bus.cmd_col, bus.cmd_ap, op, bg, ba, 16'(row), 10'(col), ap);
      end
    end
    bus.cmd_ready = 1'b1;
  endtask

  // Current cycle: first IDLE cycle with the flush pending
  task automatic service_flush(input int stall);
    bit any;
    any = 1'b0;
    for (int b = 0; b < 16; b++) any |= m_open[b];
    if (any) begin
      expect_cmd(OP_PREA, 0, 0, 0, 0, 1'b0, 1, stall, -1, "prea");
      model_clear();
      for (int i = 0; i < int'(T_RP); i++) begin
        step();
        checks++;
        if (bus.cmd_valid !== 1'b0 || bus.flush_done !== 1'(i == int'(T_RP) - 1) ||
            bus.req_ready !== 1'(i == int'(T_RP) - 1)) begin
          failures++;
          $display("FAIL flush_rpa_wait: cycle=%0d i=%0d cmd_valid=%0b flush_done=%0b req_ready=%0b required 0/%0b/%0b",
                   cyc, i, bus.cmd_valid, bus.flush_done, bus.req_ready,
                   (i == int'(T_RP) - 1), (i == int'(T_RP) - 1));
        end
      end
    end else begin
      step();
      checks++;
      if (bus.cmd_valid !== 1'b0 || bus.flush_done !== 1'b1 || bus.req_ready !== 1'b1) begin
        failures++;
        $display("FAIL flush_closed: cycle=%0d cmd_valid=%0b flush_done=%0b req_ready=%0b required 0/1/1",
                 cyc, bus.cmd_valid, bus.flush_done, bus.req_ready);
      end
    end
    step();
    checks++;
    if (bus.flush_done !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_pulse_end: cycle=%0d flush_done=%0b busy=%0b req_ready=%0b required 0/0/1",
               cyc, bus.flush_done, bus.busy, bus.req_ready);
    end
    $display("flush: %s done at cycle %0d", any ? "PREA" : "no-op", cyc);
  endtask

  // Current cycle: the RD/WR accept cycle
  task automatic finish_after_rw(input bit pend, input int stall);
    int g;
    g = AP ? int'(T_RP) : 1;
    for (int i = 0; i < g; i++) begin
      step();
      checks++;
      if (bus.cmd_valid !== 1'b0 || bus.req_ready !== 1'((i == g - 1) && !pend)) begin
        failures++;
        $display("FAIL post_rw: cycle=%0d i=%0d cmd_valid=%0b req_ready=%0b required 0/%0b",
                 cyc, i, bus.cmd_valid, bus.req_ready, ((i == g - 1) && !pend));
      end
    end
    if (pend) service_flush(stall);
  endtask

  // Current cycle: idle with req_ready expected high
  task automatic do_request(input bit we, input int bg, input int ba, input int row,
                            input int col, input int stall, input int flush_at);
    int    idx;
    bit    pend;
    string kind;
    idx  = bg * 4 + ba;
    pend = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_idle: cycle=%0d req_ready=%0b required 1", cyc, bus.req_ready);
    end
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_bg    = 2'(bg);
    bus.req_ba    = 2'(ba);
    bus.req_row   = 16'(row);
    bus.req_col   = 10'(col);
    if (m_open[idx] && m_row[idx] == 16'(row)) begin
      kind = "hit";
      expect_cmd(we ? OP_WR : OP_RD, bg, ba, 0, col, AP, 1, stall, -1, "rw");
    end else begin
      pend = (flush_at >= 0) && (flush_at < int'(T_RCD) - 1);
      if (m_open[idx]) begin
        kind = "conflict";
        expect_cmd(OP_PRE, bg, ba, 0, 0, 1'b0, 1, stall, -1, "pre");
        m_open[idx] = 1'b0;
        expect_cmd(OP_ACT, bg, ba, row, 0, 1'b0, int'(T_RP), stall, -1, "act");
      end else begin
        kind = "closed";
        expect_cmd(OP_ACT, bg, ba, row, 0, 1'b0, 1, stall, -1, "act");
      end
      m_open[idx] = 1'b1;
      m_row[idx]  = 16'(row);
      expect_cmd(we ? OP_WR : OP_RD, bg, ba, 0, col, AP, int'(T_RCD), stall,
                 pend ? flush_at : -1, "rw");
    end
    if (AP) m_open[idx] = 1'b0;
    $display("req: %s we=%0b bg=%0d ba=%0d row=0x%04h col=0x%03h stall=%0d flush=%0b cycle=%0d",
             kind, we, bg, ba, 16'(row), 10'(col), stall, pend, cyc);
    finish_after_rw(pend, stall);
  endtask

  // Flush pulse while idle
  task automatic flush_idle(input int stall);
    bus.flush = 1'b1;
    step();
    checks++;
    if (bus.flush_done !== 1'b0 || bus.busy !== 1'b1 || bus.req_ready !== 1'b0 ||
        bus.cmd_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_pending: cycle=%0d flush_done=%0b busy=%0b req_ready=%0b cmd_valid=%0b required 0/1/0/0",
               cyc, bus.flush_done, bus.busy, bus.req_ready, bus.cmd_valid);
    end
    service_flush(stall);
  endtask

  task automatic test_reset();
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_row = '0; bus.req_col = '0;
    bus.req_bg = '0; bus.req_ba = '0; bus.cmd_ready = 1'b0; bus.flush = 1'b0;
    sys_rst_n = 1'b0;
    model_clear();
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (bus.cmd_valid !== 1'b0 || bus.cmd_op !== 3'd0 || bus.cmd_bg !== 2'd0 ||
        bus.cmd_ba !== 2'd0 || bus.cmd_row !== 16'd0 || bus.cmd_col !== 10'd0 ||
        bus.cmd_ap !== 1'b0 || bus.flush_done !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: v=%0b op=%0d bg=%0d ba=%0d row=%h col=%h ap=%0b fd=%0b busy=%0b required all 0",
               bus.cmd_valid, bus.cmd_op, bus.cmd_bg, bus.cmd_ba, bus.cmd_row, bus.cmd_col,
               bus.cmd_ap, bus.flush_done, bus.busy);
    end
    sys_rst_n = 1'b1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_ready: req_ready=%0b required 1", bus.req_ready);
    end
    step();
  endtask

  task automatic test_flush_closed();
    flush_idle(0);
  endtask

  task automatic test_read_closed();
    do_request(1'b0, 1, 2, 'h0123, 'h010, 0, -1);
  endtask

  task automatic test_hit();
    do_request(1'b0, 1, 2, 'h0123, 'h010, 0, -1);
  endtask

  task automatic test_conflict();
    do_request(1'b1, 1, 2, 'h0456, 'h155, 0, -1);
  endtask

  task automatic test_stall();
    do_request(1'b0, 0, 1, 'h0abc, 'h3ff, 5, -1);
  endtask

  task automatic test_flush_during_rcd();
    do_request(1'b0, 2, 0, 'h1111, 'h022, 0, 1);
    do_request(1'b0, 1, 2, 'h0456, 'h033, 0, -1);
  endtask

  task automatic test_random();
    int rows [3];
    int fa;
    rows[0] = 'h0123; rows[1] = 'h0456; rows[2] = 'hbeef;
    for (int n = 0; n < 40; n++) begin
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, T_RCD - 2)) : -1;
      do_request(1'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)), rows[$urandom_range(0, 2)],
                 int'($urandom_range(0, 1023)), int'($urandom_range(0, 2)), fa);
      if ($urandom_range(0, 5) == 0) flush_idle(int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_abort();
    do_request(1'b0, 3, 3, 'h0777, 'h001, 0, -1);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_bg = 2'd3; bus.req_ba = 2'd3;
    bus.req_row = 16'h0888; bus.req_col = 10'h002;
    step();
    checks++;
    if (bus.cmd_valid !== 1'b1) begin
      failures++;
      $display("FAIL abort_precmd: cycle=%0d cmd_valid=%0b required 1", cyc, bus.cmd_valid);
    end
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (bus.cmd_valid !== 1'b0 || bus.cmd_op !== 3'd0 || bus.req_ready !== 1'b1 ||
        bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset: cmd_valid=%0b op=%0d req_ready=%0b busy=%0b required 0/0/1/0",
               bus.cmd_valid, bus.cmd_op, bus.req_ready, bus.busy);
    end
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    model_clear();
    // Same bank/row as before the reset must now classify as closed
    do_request(1'b0, 3, 3, 'h0777, 'h004, 0, -1);
  endtask

  initial begin
    test_reset();
    test_flush_closed();
    test_read_closed();
    test_hit();
    test_conflict();
    test_stall();
    test_flush_during_rcd();
    test_random();
    flush_idle(1);
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
